// File: rtl/decoder_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : decoder_addr_sequencer
// Description : Drives the 3-bit select (A2,A1,A0) of a downstream 3-to-8
//               decoder. Scans codes 000..111 ascending or descending and
//               holds each code for (dwell+1) cycles. Runs once (one-shot) or
//               continuously (loop), and reports progress on busy/step/done.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               start, stop      - begin scan (IDLE only) / abort (RUN only)
//               dir_down         - 0: 000->111, 1: 111->000 (latched at start)
//               loop_en          - 1: wrap and continue (latched at start)
//               dwell[DWELL_W]   - extra hold cycles per code (latched)
//               A2, A1, A0       - registered select to decoder
//               busy             - high while scanning
//               step             - one-cycle pulse on each code advance/wrap
//               done             - one-cycle pulse on one-shot completion
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_addr_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir_down,
  input  logic               loop_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A2,
  output logic               A1,
  output logic               A0,
  output logic               busy,
  output logic               step,
  output logic               done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [2:0]         code;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q;
  logic               loop_q;

  // Last code of a pass depends on the latched direction.
  logic terminal;
  assign terminal = dir_q ? (code == 3'b000) : (code == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code    <= 3'b000;
      cnt     <= '0;
      dwell_q <= '0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
      busy    <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_q   <= dir_down;
            loop_q  <= loop_en;
            dwell_q <= dwell;
            code    <= dir_down ? 3'b111 : 3'b000;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // stop wins over a same-cycle code event or completion.
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == dwell_q) begin
            cnt <= '0;
            if (!terminal) begin
              code <= dir_q ? (code - 3'd1) : (code + 3'd1);
              step <= 1'b1;
            end else if (loop_q) begin
              code <= dir_q ? 3'b111 : 3'b000;
              step <= 1'b1;
            end else begin
              // One-shot complete: terminal code stays on the outputs.
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign A2 = code[2];
  assign A1 = code[1];
  assign A0 = code[0];

endmodule
`default_nettype wire

// File: tb/tb_decoder_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_addr_sequencer
// Description : Self-checking bench for decoder_addr_sequencer. A reference
//               model derives the expected code from the elapsed time since
//               start: position n = t / (D+1), code = n mod 8 (mirrored for
//               descending), step on t mod (D+1) == 0, one-shot end at
//               t = 8(D+1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_addr_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir_down = 1'b0;
  logic          loop_en = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          A2, A1, A0, busy, step, done;

  decoder_addr_sequencer #(.DWELL_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .dir_down (dir_down),
    .loop_en  (loop_en),
    .dwell    (dwell),
    .A2       (A2),
    .A1       (A1),
    .A0       (A0),
    .busy     (busy),
    .step     (step),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_run;
  int m_t, m_d, m_code;
  bit m_dir, m_loop, m_step, m_done;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_d = 0; m_code = 0;
    m_dir = 0; m_loop = 0; m_step = 0; m_done = 0;
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_edge();
    int n;
    m_step = 0;
    m_done = 0;
    if (!m_run) begin
      if (start) begin
        m_run  = 1;
        m_t    = 0;
        m_d    = int'(dwell);
        m_dir  = dir_down;
        m_loop = loop_en;
        m_code = m_dir ? 7 : 0;
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      m_t++;
      if (!m_loop && m_t == 8 * (m_d + 1)) begin
        m_run  = 0;
        m_done = 1;
      end else begin
        n      = (m_t / (m_d + 1)) % 8;
        m_code = m_dir ? (7 - n) : n;
        m_step = (m_t % (m_d + 1)) == 0;
      end
    end
  endtask

  task automatic check_all();
    check("code", 32'({A2, A1, A0}), 32'(m_code));
    check("busy", 32'(busy), 32'(m_run));
    check("step", 32'(step), 32'(m_step));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic start_scan(input int d, input bit dir, input bit lp);
    dwell = DW'(d); dir_down = dir; loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_code(input int target, input int budget, input string tag);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if ({A2, A1, A0} == 3'(target)) found = 1;
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_oneshot(input int d, input bit dir, input string tag);
    int busyc, steps, dones;
    start_scan(d, dir, 1'b0);
    busyc = int'(busy); steps = 0; dones = 0;
    for (int i = 0; i < 8 * (d + 1); i++) begin
      tick();
      busyc += int'(busy); steps += int'(step); dones += int'(done);
    end
    check({tag, "_busy_cycles"}, 32'(busyc), 32'(8 * (d + 1)));
    check({tag, "_steps"}, 32'(steps), 32'd7);
    check({tag, "_dones"}, 32'(dones), 32'd1);
    check({tag, "_done_last"}, 32'(done), 32'd1);
    check({tag, "_final_code"}, 32'({A2, A1, A0}), dir ? 32'd0 : 32'd7);
    tick();
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones, steps, wraps, hold7;
    logic [2:0] prev;
    model_reset();

    // Reset state
    #12;
    check("rst_code", 32'({A2, A1, A0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Ascending one-shot, one cycle per code; descending with dwell 2
    run_oneshot(0, 1'b0, "asc");
    run_oneshot(2, 1'b1, "desc");

    // Loop wrap over three periods
    start_scan(1, 1'b0, 1'b1);
    dones = 0; steps = 0; wraps = 0;
    for (int i = 0; i < 48; i++) begin
      prev = {A2, A1, A0};
      tick();
      dones += int'(done); steps += int'(step);
      if (prev == 3'd7 && {A2, A1, A0} == 3'd0 && step) wraps++;
    end
    check("loop_dones", 32'(dones), 32'd0);
    check("loop_steps", 32'(steps), 32'd24);
    check("loop_wraps", 32'(wraps), 32'd3);
    stop = 1'b1; tick(); stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'd0);

    // Stop colliding with terminal completion
    start_scan(0, 1'b0, 1'b0);
    wait_code(7, 20, "stop7");
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop7_code", 32'({A2, A1, A0}), 32'd7);
    check("stop7_busy", 32'(busy), 32'd0);
    check("stop7_done", 32'(done), 32'd0);
    repeat (3) tick();

    // Stop mid-dwell at code 100
    start_scan(3, 1'b0, 1'b0);
    wait_code(4, 40, "stop4");
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop4_code", 32'({A2, A1, A0}), 32'd4);
    repeat (6) tick();
    check("stop4_hold", 32'({A2, A1, A0}), 32'd4);

    // Config latch, then back-to-back start in the done cycle
    start_scan(1, 1'b0, 1'b0);
    repeat (5) tick();
    dwell = DW'(5); dir_down = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick();
        if (done) got = 1;
      end
      if (!got) check("cfg_done_timeout", 32'd0, 32'd1);
    end
    start = 1'b1; tick(); start = 1'b0;
    check("cfg_second_code", 32'({A2, A1, A0}), 32'd7);
    check("cfg_second_busy", 32'(busy), 32'd1);
    hold7 = 1;
    for (int i = 0; i < 48; i++) begin
      tick();
      if ({A2, A1, A0} == 3'd7 && busy) hold7++;
    end
    check("cfg_second_hold7", 32'(hold7), 32'd6);

    // Asynchronous reset during the third code
    start_scan(2, 1'b0, 1'b0);
    wait_code(2, 20, "rst_mid");
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rstmid_code", 32'({A2, A1, A0}), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_step", 32'(step), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    repeat (5) tick();

    // All-ones dwell: 256 cycles per code
    run_oneshot(255, 1'b0, "maxdwell");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom % 6) == 0;
      stop     = ($urandom % 24) == 0;
      dir_down = 1'($urandom);
      loop_en  = 1'($urandom);
      dwell    = DW'($urandom % 4);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_addr_sequencer.md
# decoder_addr_sequencer

Sequencer directly upstream of the 3-to-8 decoder: it generates the 3-bit select A2,A1,A0 that drives the decoder inputs. The select steps through codes 000..111, ascending or descending. Each code is held for a programmable dwell time. The block runs either once (one-shot) or continuously (loop) and reports progress with busy, step and done strobes. Its outputs connect bit-for-bit to the decoder's A2/A1/A0 inputs.

## Interface
Parameters:
- DWELL_W, 8, width of dwell field; each code is held dwell+1 cycles.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort a scan; sampled only in RUN.
- dir_down  input  1  0 = 000→111, 1 = 111→000; latched at start.
- loop_en  input  1  1 = wrap and continue, 0 = one-shot; latched at start.
- dwell  input  DWELL_W  hold count per code; latched at start.
- A2  output  1  select MSB to decoder.
- A1  output  1  select bit 1 to decoder.
- A0  output  1  select LSB to decoder.
- busy  output  1  high while in RUN.
- step  output  1  one-cycle pulse when the code advances or wraps during RUN.
- done  output  1  one-cycle pulse on natural one-shot completion.

## Operation
- Reset (async, rst_n=0):
  - State IDLE.
  - {A2,A1,A0}=000; busy=0, step=0, done=0.
  - Dwell counter=0; latched config cleared to 0.
- States are IDLE and RUN. All outputs are registered.
- IDLE:
  - The code holds its last value.
  - start=1: latch dir_down, loop_en, dwell. Load code = dir_down ? 111 : 000. Clear dwell counter. Go to RUN.
  - stop is ignored.
- RUN:
  - Each cycle the dwell counter increments.
  - When the counter equals the latched dwell, it clears to 0 and the code event fires.
- Code event:
  - Code is not terminal (terminal is 111 ascending, 000 descending): code ±1 (mod 8), step=1.
  - Terminal and loop_en=1: code wraps to the start code (000 ascending, 111 descending), step=1.
  - Terminal and loop_en=0: go to IDLE, done=1, step=0, code holds the terminal value.
- stop=1 in RUN:
  - Go to IDLE on that edge; code holds its current value.
  - done=0, step=0.
  - stop takes priority over any same-cycle code event or completion.
- start while in RUN is ignored. Input changes to dwell, dir_down or loop_en during RUN have no effect.
- Arithmetic:
  - Code is a 3-bit unsigned value with modulo-8 wrap.
  - Dwell counter is DWELL_W bits and never exceeds the latched dwell.
  - dwell=0 means one cycle per code.
  - dwell = all ones means 2^DWELL_W cycles per code.

## Timing
- start sampled high at edge k: busy=1 and the start code are valid after edge k.
- Code n (0-based) is valid for cycles [k + n(D+1), k + (n+1)(D+1)), where D is the latched dwell.
- One-shot: busy is high for exactly 8(D+1) cycles.
  - done and busy=0 appear together after edge k + 8(D+1).
  - done is high for one cycle.
- step is high during the first cycle each new code is valid. There are 7 step pulses per one-shot pass; the initial load does not pulse step.
- Loop: the period is 8(D+1) cycles. step pulses every D+1 cycles, including the wrap.
- stop sampled at edge m: busy=0 after edge m, and the code is frozen at its value before edge m.
- start sampled in the same cycle that done is pulsed (block already in IDLE): accepted, so back-to-back scans are possible with a single idle cycle.
- rst_n asserted mid-scan: outputs go immediately (asynchronously) to reset values with no done pulse. After rst_n deasserts, the block waits in IDLE for start.

## Test plan
- Reset mid-scan:
  - Stimulus: assert rst_n=0 during the 3rd code of an ascending scan.
  - Required: A2A1A0=000, busy=0, step=0, done=0 immediately; no activity until the next start.
- Ascending one-shot:
  - Stimulus: dwell=0, dir_down=0, loop_en=0, start pulse.
  - Required: codes 000,001,…,111, one per cycle. busy high 8 cycles. 7 step pulses. done pulse after 111. Code holds 111.
- Descending with dwell:
  - Stimulus: dwell=2, dir_down=1, start.
  - Required: each code 111,110,…,000 held 3 cycles. busy high 24 cycles. done after the 3rd cycle of 000.
- Loop wrap:
  - Stimulus: dwell=1, loop_en=1, ascending.
  - Required: 111 is followed by 000 with step=1. Period is 16 cycles. done never asserts over 3 periods.
- Stop vs. terminal collision:
  - Stimulus: one-shot with dwell=0; assert stop in the cycle code=111.
  - Required: busy drops, done=0, code holds 111.
  - Stimulus: assert stop at code 100 with dwell=3.
  - Required: code frozen at 100.
- Config latch:
  - Stimulus: start with dwell=1; change dwell to 5 and dir_down to 1 mid-scan; then issue start in the done cycle.
  - Required: the first scan keeps 2-cycle ascending steps. The second scan begins immediately with code 111 and 6-cycle dwell.
